reduce_vector: RTL and testbench

Sums the N elements of a floating-point vector into one scalar, using a single shared `add` instance in a sequential loop. It sits directly downstream of `add_vector` and consumes its `c[N]` / `out_valid` result, for example to form the final sum of a dot product or a vector norm. The summation order is fixed left-to-right, so results are bit-exact against a software model that uses the same order.

---
 rtl/reduce_vector.sv | 194 +++++++++++++++++++
 tb/tb_reduce_vector.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/reduce_vector.sv
// Sums an N-element floating-point vector left to right through one shared adder.
// The adder below is the shared `add` (one-cycle latency, round-to-nearest-even).

module add #(
    parameter int    BITS      = 16,
    parameter string PRECISION = "HALF"
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            in_valid,
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    output logic            out_valid,
    output logic [BITS-1:0] c
);
    localparam int EW = (PRECISION == "SINGLE" || PRECISION == "BFLOAT") ? 8 :
                        (PRECISION == "DOUBLE") ? 11 : 5;
    localparam int MW = BITS - 1 - EW;
    // Mantissa working width: hidden bit, fraction, guard/round/sticky.
    localparam int W  = MW + 4;
    localparam logic [EW-1:0]   EMAX = '1;
    localparam logic [BITS-1:0] QNAN = {1'b0, EMAX, 1'b1, {(MW-1){1'b0}}};

    logic            swap, eff_sub, sticky_in, rnd_up, res_sign;
    logic            a_nan, b_nan, a_inf, b_inf;
    logic [BITS-1:0] big, sml, res;
    logic [EW-1:0]   e_big, e_sml, e_big_eff, e_sml_eff;
    logic [EW:0]     d;
    logic [EW+1:0]   e_n;
    logic [W-1:0]    m_big, m_sml, m_shr, m_aln, m_n;
    logic [W:0]      m_sum;
    int              lz, sh;

    always_comb begin
        swap      = a[BITS-2:0] < b[BITS-2:0];
        big       = swap ? b : a;
        sml       = swap ? a : b;
        e_big     = big[BITS-2:MW];
        e_sml     = sml[BITS-2:MW];
        e_big_eff = (e_big == '0) ? EW'(1) : e_big;
        e_sml_eff = (e_sml == '0) ? EW'(1) : e_sml;
        m_big     = {|e_big, big[MW-1:0], 3'b000};
        m_sml     = {|e_sml, sml[MW-1:0], 3'b000};
        d = {1'b0, e_big_eff} - {1'b0, e_sml_eff};
        if (d > (EW+1)'(W)) d = (EW+1)'(W);
        m_shr     = m_sml >> d;
        sticky_in = (m_shr << d) != m_sml;
        m_aln     = m_shr | {{(W-1){1'b0}}, sticky_in};
        eff_sub   = big[BITS-1] ^ sml[BITS-1];
        m_sum = eff_sub ? ({1'b0, m_big} - {1'b0, m_aln}) : ({1'b0, m_big} + {1'b0, m_aln});

        lz = W;
        for (int i = 0; i < W; i++) begin
            if (m_sum[i]) lz = W - 1 - i;
        end
        sh = 0;
        if (m_sum[W]) begin
            m_n = m_sum[W:1] | {{(W-1){1'b0}}, m_sum[0]};
            e_n = {2'b00, e_big_eff} + (EW+2)'(1);
        end else begin
            // Left shift stops at the minimum exponent so subnormals come out naturally.
            sh  = (lz < int'(e_big_eff) - 1) ? lz : int'(e_big_eff) - 1;
            m_n = m_sum[W-1:0] << sh;
            e_n = {2'b00, e_big_eff} - (EW+2)'(sh);
        end
        if (!m_n[W-1]) e_n = '0;

        rnd_up   = m_n[2] & (m_n[1] | m_n[0] | m_n[3]);
        res_sign = (m_sum == '0) ? (a[BITS-1] & b[BITS-1]) : big[BITS-1];
        // A rounding carry ripples from fraction into exponent, reaching inf if needed.
        if (e_n >= {2'b00, EMAX}) res = {res_sign, EMAX, {MW{1'b0}}};
        else                      res = {res_sign, {e_n[EW-1:0], m_n[W-2:3]} + (BITS-1)'(rnd_up)};

        a_nan = (a[BITS-2:MW] == EMAX) && (a[MW-1:0] != '0);
        b_nan = (b[BITS-2:MW] == EMAX) && (b[MW-1:0] != '0);
        a_inf = (a[BITS-2:MW] == EMAX) && (a[MW-1:0] == '0);
        b_inf = (b[BITS-2:MW] == EMAX) && (b[MW-1:0] == '0);
        if (a_nan || b_nan || (a_inf && b_inf && (a[BITS-1] != b[BITS-1]))) res = QNAN;
        else if (a_inf) res = a;
        else if (b_inf) res = b;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            c         <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) c <= res;
        end
    end
endmodule

module reduce_vector #(
    parameter int    BITS      = 16,
    parameter string PRECISION = "HALF",
    parameter int    N         = 3
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            in_valid,
    input  logic [BITS-1:0] x [N],
    output logic            in_ready,
    output logic            out_valid,
    output logic [BITS-1:0] sum,
    output logic            overrun
);
    localparam int IW = $clog2(N) + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t          state, state_nxt;
    logic [BITS-1:0] xr [N];
    logic [BITS-1:0] acc, b_sel, add_c;
    logic [IW-1:0]   idx;
    logic            add_go, add_ov, accept, step;

    // Handshake: a vector is taken on any edge where in_valid && in_ready; there is
    // no backpressure upstream, so in_valid while busy is dropped and flagged as overrun.
    assign in_ready = (state == IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        add_go    = 1'b0;
        accept    = 1'b0;
        step      = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = (N == 1) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                add_go    = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (add_ov) begin
                    step      = 1'b1;
                    state_nxt = (idx == IW'(N - 1)) ? DONE : ISSUE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        b_sel = '0;
        for (int i = 0; i < N; i++) begin
            if (idx == IW'(i)) b_sel = xr[i];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < N; i++) xr[i] <= '0;
            acc       <= '0;
            idx       <= '0;
            sum       <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            out_valid <= (state == DONE);
            overrun   <= in_valid && (state != IDLE);
            if (accept) begin
                xr  <= x;
                acc <= x[0];
                idx <= IW'(1);
            end
            if (step) begin
                acc <= add_c;
                idx <= idx + 1'b1;
            end
            if (state == DONE) sum <= acc;
        end
    end

    add #(.BITS(BITS), .PRECISION(PRECISION)) u_add (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (add_go),
        .a         (acc),
        .b         (b_sel),
        .out_valid (add_ov),
        .c         (add_c)
    );
endmodule

// File: tb/tb_reduce_vector.sv
// Directed bench for reduce_vector: HALF N=3 instance plus an N=1 instance.
module tb_reduce_vector;
    localparam int L   = 1;
    localparam int LAT = 2 * L + 4;

    logic        clk, rstn;
    logic        in_valid, in_ready, out_valid, overrun;
    logic [15:0] x [3];
    logic [15:0] sum;
    logic        in_valid1, in_ready1, out_valid1, overrun1;
    logic [15:0] x1 [1];
    logic [15:0] sum1;

    int n_vec = 0;
    int n_err = 0;
    int ov_cnt = 0;
    int ovr_cnt = 0;
    int add1_cnt = 0;
    int ov_snap, ovr_snap;

    reduce_vector #(.BITS(16), .PRECISION("HALF"), .N(3)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .x(x),
        .in_ready(in_ready), .out_valid(out_valid), .sum(sum), .overrun(overrun)
    );

    reduce_vector #(.BITS(16), .PRECISION("HALF"), .N(1)) dut1 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid1), .x(x1),
        .in_ready(in_ready1), .out_valid(out_valid1), .sum(sum1), .overrun(overrun1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (out_valid) ov_cnt++;
        if (overrun) ovr_cnt++;
        if (dut1.add_go) add1_cnt++;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_vec(input logic [15:0] v0, input logic [15:0] v1, input logic [15:0] v2);
        x[0] = v0;
        x[1] = v1;
        x[2] = v2;
    endtask

    // Present a vector in the current cycle (T) and check the IDLE handshake.
    task automatic send(input string tag, input logic [15:0] v0, input logic [15:0] v1,
                        input logic [15:0] v2);
        check({tag, "_ready"}, {15'd0, in_ready}, 16'd1);
        set_vec(v0, v1, v2);
        in_valid = 1'b1;
    endtask

    // Step until out_valid (bounded), then check latency, sum, busy window and ready.
    task automatic run_to_result(input string tag, input logic [15:0] exp_sum);
        int   lat;
        logic busy_bad;
        lat      = 0;
        busy_bad = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) in_valid = 1'b0;
            if (out_valid) begin
                lat = k;
                break;
            end
            if (in_ready) busy_bad = 1'b1;
        end
        check({tag, "_latency"}, 16'(lat), 16'(LAT));
        check({tag, "_sum"}, sum, exp_sum);
        check({tag, "_busy"}, {15'd0, busy_bad}, 16'd0);
        check({tag, "_ready_at_done"}, {15'd0, in_ready}, 16'd1);
    endtask

    initial begin
        rstn      = 1'b0;
        in_valid  = 1'b0;
        in_valid1 = 1'b0;
        set_vec(16'h0, 16'h0, 16'h0);
        x1[0] = 16'h0;
        repeat (2) @(negedge clk);
        check("rst_sum", sum, 16'h0000);
        check("rst_out_valid", {15'd0, out_valid}, 16'd0);
        check("rst_overrun", {15'd0, overrun}, 16'd0);
        check("rst_in_ready", {15'd0, in_ready}, 16'd1);
        check("rst_sum1", sum1, 16'h0000);
        rstn = 1'b1;
        @(negedge clk);

        // Basic sum 1+2+3 = 6, then pulse must drop and sum must hold.
        send("s1", 16'h3C00, 16'h4000, 16'h4200);
        run_to_result("s1", 16'h4600);
        @(negedge clk);
        check("s1_pulse_end", {15'd0, out_valid}, 16'd0);
        check("s1_sum_hold", sum, 16'h4600);

        // Cancellation then overflow to +inf in left-to-right order.
        send("s2a", 16'h3C00, 16'hBC00, 16'h4000);
        run_to_result("s2a", 16'h4000);
        @(negedge clk);
        send("s2b", 16'h7BFF, 16'h7BFF, 16'hFBFF);
        run_to_result("s2b", 16'h7C00);
        @(negedge clk);

        // Back-to-back: second vector accepted in the out_valid cycle of the first.
        ovr_snap = ovr_cnt;
        send("s3a", 16'h3C00, 16'h4000, 16'h4200);
        run_to_result("s3a", 16'h4600);
        send("s3b", 16'h4400, 16'h4400, 16'h4400);
        run_to_result("s3b", 16'h4A00);
        @(negedge clk);
        @(negedge clk);
        check("s3_no_overrun", 16'(ovr_cnt - ovr_snap), 16'd0);

        // Overrun: in_valid at T+3 while busy.
        ov_snap  = ov_cnt;
        ovr_snap = ovr_cnt;
        send("s4", 16'h3C00, 16'h4000, 16'h4200);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        set_vec(16'h7C00, 16'h7C00, 16'h7C00);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("s4_overrun_pulse", {15'd0, overrun}, 16'd1);
        @(negedge clk);
        check("s4_overrun_clear", {15'd0, overrun}, 16'd0);
        @(negedge clk);
        check("s4_out_valid", {15'd0, out_valid}, 16'd1);
        check("s4_sum", sum, 16'h4600);
        @(negedge clk);
        check("s4_one_result", 16'(ov_cnt - ov_snap), 16'd1);
        check("s4_one_overrun", 16'(ovr_cnt - ovr_snap), 16'd1);

        // Reset during WAIT of the second add (cycle T+4).
        send("s5", 16'h3C00, 16'h4000, 16'h4200);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        check("s5_rst_sum", sum, 16'h0000);
        check("s5_rst_out_valid", {15'd0, out_valid}, 16'd0);
        check("s5_rst_in_ready", {15'd0, in_ready}, 16'd1);
        ov_snap = ov_cnt;
        rstn = 1'b1;
        @(negedge clk);
        send("s5b", 16'h3C00, 16'h3C00, 16'h3C00);
        run_to_result("s5b", 16'h4200);
        @(negedge clk);
        check("s5_no_stale", 16'(ov_cnt - ov_snap), 16'd1);

        // N=1 instance: result at T+2, adder never issued.
        check("s6_ready", {15'd0, in_ready1}, 16'd1);
        x1[0]     = 16'hC500;
        in_valid1 = 1'b1;
        @(negedge clk);
        in_valid1 = 1'b0;
        check("s6_t1_out_valid", {15'd0, out_valid1}, 16'd0);
        check("s6_t1_busy", {15'd0, in_ready1}, 16'd0);
        @(negedge clk);
        check("s6_out_valid", {15'd0, out_valid1}, 16'd1);
        check("s6_sum", sum1, 16'hC500);
        check("s6_ready_at_done", {15'd0, in_ready1}, 16'd1);
        @(negedge clk);
        check("s6_pulse_end", {15'd0, out_valid1}, 16'd0);
        check("s6_no_add_issue", 16'(add1_cnt), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
